// File: rtl/data_memory_pkg.sv
// Shared types and constants for the data memory arbiter.
// Imported by the arbiter top.
package data_memory_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    COMPLETE
  } arb_state_t;

  typedef logic req_id_t;

  localparam int DATA_MEM_DEPTH   = 512;
  localparam int DATA_MEM_LATENCY = 5;

endpackage

// File: rtl/data_memory_arbiter.sv
// Round-robin two-port front end for the single-ported data memory.
// Range-checks, holds strobes for MEM_LATENCY clocks, pulses ack.
module data_memory_arbiter
  import data_memory_pkg::*;
#(
  parameter int MEM_LATENCY = DATA_MEM_LATENCY,
  parameter int DEPTH       = DATA_MEM_DEPTH
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic        ack0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack1,
  output logic [31:0] rdata1,
  output logic        err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        busy
);

  localparam int CW =
    (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [CW-1:0] CNT_INIT =
    CW'(MEM_LATENCY - 1);

  arb_state_t    state, state_n;
  req_id_t       last_grant, last_grant_n;
  req_id_t       id, id_n;
  logic          lat_we, lat_we_n;
  logic [CW-1:0] cnt, cnt_n;

  logic          ack0_n, ack1_n, err_n;
  logic [31:0]   rdata0_n, rdata1_n;
  logic          mem_read_n, mem_write_n;
  logic [31:0]   mem_address_n, mem_write_data_n;

  req_id_t       pick;
  logic          pw;
  logic [31:0]   pa, pd;

  always_comb begin
    pick = (req0 & req1) ? ~last_grant : req1;
    pw   = pick ? we1    : we0;
    pa   = pick ? addr1  : addr0;
    pd   = pick ? wdata1 : wdata0;
  end

  always_comb begin
    state_n          = state;
    last_grant_n     = last_grant;
    id_n             = id;
    lat_we_n         = lat_we;
    cnt_n            = cnt;
    ack0_n           = 1'b0;
    ack1_n           = 1'b0;
    err_n            = 1'b0;
    rdata0_n         = rdata0;
    rdata1_n         = rdata1;
    mem_read_n       = mem_read;
    mem_write_n      = mem_write;
    mem_address_n    = mem_address;
    mem_write_data_n = mem_write_data;
    unique case (state)
      IDLE: begin
        if (req0 | req1) begin
          id_n     = pick;
          lat_we_n = pw;
          if (pa < DEPTH_W) begin
            state_n          = ACCESS;
            cnt_n            = CNT_INIT;
            mem_address_n    = pa;
            mem_write_data_n = pd;
            mem_write_n      = pw;
            mem_read_n       = ~pw;
          end else begin
            // Out of range: memory never sees it
            state_n = COMPLETE;
            err_n   = 1'b1;
            ack0_n  = ~pick;
            ack1_n  = pick;
          end
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          state_n     = COMPLETE;
          mem_read_n  = 1'b0;
          mem_write_n = 1'b0;
          ack0_n      = ~id;
          ack1_n      = id;
          if (!lat_we) begin
            if (id) rdata1_n = mem_read_data;
            else    rdata0_n = mem_read_data;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      COMPLETE: begin
        state_n      = IDLE;
        last_grant_n = id;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      id             <= 1'b0;
      lat_we         <= 1'b0;
      cnt            <= '0;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      err            <= 1'b0;
      rdata0         <= '0;
      rdata1         <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      busy           <= 1'b0;
    end else begin
      state          <= state_n;
      last_grant     <= last_grant_n;
      id             <= id_n;
      lat_we         <= lat_we_n;
      cnt            <= cnt_n;
      ack0           <= ack0_n;
      ack1           <= ack1_n;
      err            <= err_n;
      rdata0         <= rdata0_n;
      rdata1         <= rdata1_n;
      mem_read       <= mem_read_n;
      mem_write      <= mem_write_n;
      mem_address    <= mem_address_n;
      mem_write_data <= mem_write_data_n;
      busy           <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter with a behavioural
// memory; stimulus pushes expected acks, a monitor checks them.
module tb_data_memory_arbiter;

  localparam int LAT = 5;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, ack1, err, busy;
  logic [31:0] rdata0, rdata1;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  typedef struct {
    bit          port;
    bit          err;
    bit          chk;
    logic [31:0] rdata;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_rd [2];

  logic [31:0] mem [512];
  bit          mem_init = 1'b0;

  data_memory_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .req0           (req0),
    .we0            (we0),
    .addr0          (addr0),
    .wdata0         (wdata0),
    .ack0           (ack0),
    .rdata0         (rdata0),
    .req1           (req1),
    .we1            (we1),
    .addr1          (addr1),
    .wdata1         (wdata1),
    .ack1           (ack1),
    .rdata1         (rdata1),
    .err            (err),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  assign mem_read_data = mem[mem_address[8:0]];

  always @(posedge clock) begin
    if (!mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'(i * 3);
      mem[4]   <= 32'd500;
      mem[8]   <= 32'hFFFF_FFFE;
      mem_init <= 1'b1;
    end else if (mem_write) begin
      mem[mem_address[8:0]] <= mem_write_data;
    end
  end

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin : mon
    exp_t e;
    if (!reset && (ack0 || ack1)) begin
      tests++;
      if (ack0 && ack1) begin
        fails++;
        $display("FAIL both_ack: got ack0=1 ack1=1 expected one");
      end else if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ack: got ack0=%b ack1=%b expected none",
                 ack0, ack1);
      end else begin
        e = q.pop_front();
        if (ack1 != e.port || err != e.err ||
            (e.chk && (ack1 ? rdata1 : rdata0) != e.rdata)) begin
          fails++;
          $display("FAIL ack_data: got port=%0d err=%b rdata=%h expected port=%0d err=%b rdata=%h",
                   ack1, err, ack1 ? rdata1 : rdata0,
                   e.port, e.err, e.rdata);
        end
      end
    end
  end

  task automatic check_reset_state(input string name);
    logic [133:0] v;
    v = {ack0, ack1, err, busy, mem_read, mem_write,
         rdata0, rdata1, mem_address, mem_write_data};
    check(v == '0, name, {31'd0, |v}, 32'd0);
  endtask

  task automatic do_access(input bit p, input bit w,
                           input logic [31:0] a,
                           input logic [31:0] d,
                           input bit early_drop);
    bit          oor;
    bit          seen;
    bit          bad;
    int          lat;
    int          strobes;
    logic [31:0] er;
    oor = (a >= 32'd512);
    seen = 0; bad = 0; lat = 0; strobes = 0;
    er = w ? last_rd[p] : mem[a[8:0]];
    q.push_back('{port: p, err: oor, chk: !oor, rdata: er});
    if (!oor && !w) last_rd[p] = er;
    if (p) begin
      req1 = 1; we1 = w; addr1 = a; wdata1 = d;
    end else begin
      req0 = 1; we0 = w; addr0 = a; wdata0 = d;
    end
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clock);
      if (early_drop && i == 1) begin
        if (p) req1 = 0; else req0 = 0;
      end
      if (mem_read || mem_write) begin
        strobes++;
        if (mem_address != a || mem_write != w ||
            mem_read == w || (w && mem_write_data != d))
          bad = 1;
      end
      if (p ? ack1 : ack0) begin
        seen = 1;
        lat = i;
      end
    end
    if (p) req1 = 0; else req0 = 0;
    check(seen && lat == (oor ? 1 : LAT + 1), "ack_latency",
          32'(lat), oor ? 32'd1 : 32'(LAT + 1));
    check(!bad && strobes == (oor ? 0 : LAT), "strobes",
          32'(strobes), oor ? 32'd0 : 32'(LAT));
    @(negedge clock);
  endtask

  task automatic push_rd(input bit p, input logic [31:0] a);
    q.push_back('{port: p, err: 1'b0, chk: 1'b1,
                  rdata: mem[a[8:0]]});
    last_rd[p] = mem[a[8:0]];
  endtask

  task automatic run_both(input int n0, input int n1);
    int r0;
    int r1;
    r0 = n0; r1 = n1;
    we0 = 0; addr0 = 32'h4;
    we1 = 0; addr1 = 32'h8;
    req0 = (n0 > 0);
    req1 = (n1 > 0);
    for (int i = 0; i < 100 && (r0 > 0 || r1 > 0); i++) begin
      @(negedge clock);
      if (ack0) begin
        r0--;
        if (r0 == 0) req0 = 0;
      end
      if (ack1) begin
        r1--;
        if (r1 == 0) req1 = 0;
      end
    end
    req0 = 0; req1 = 0;
    check(r0 == 0 && r1 == 0, "rr_done",
          32'(r0 + r1), 32'd0);
    @(negedge clock);
  endtask

  initial begin
    reset = 1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    last_rd[0] = 0; last_rd[1] = 0;
    repeat (3) @(negedge clock);
    check_reset_state("reset_state");
    reset = 0;
    @(negedge clock);

    do_access(0, 1, 32'h10, 32'hDEAD_BEEF, 0);
    do_access(0, 0, 32'h10, 32'h0, 0);

    do_access(1, 0, 32'd600, 32'h0, 0);
    check(mem[88] == 32'd264, "oor_mem_intact",
          mem[88], 32'd264);

    push_rd(0, 32'h4);
    push_rd(1, 32'h8);
    push_rd(0, 32'h4);
    run_both(2, 1);

    req0 = 1; we0 = 1; addr0 = 32'h20; wdata0 = 32'h1234_5678;
    repeat (3) @(negedge clock);
    check(mem_write == 1'b1, "mid_access_strobe",
          {31'd0, mem_write}, 32'd1);
    reset = 1;
    #1;
    check({mem_write, mem_read, busy, ack0, ack1} == 5'd0,
          "async_drop",
          {27'd0, mem_write, mem_read, busy, ack0, ack1}, 32'd0);
    req0 = 0;
    @(negedge clock);
    check_reset_state("reset_mid_state");
    reset = 0;
    last_rd[0] = 0; last_rd[1] = 0;
    repeat (3) @(negedge clock);
    check(busy == 1'b0, "idle_after_reset",
          {31'd0, busy}, 32'd0);

    push_rd(0, 32'h4);
    push_rd(1, 32'h8);
    run_both(1, 1);

    do_access(0, 0, 32'h10, 32'h0, 1);
    do_access(1, 1, 32'h30, 32'h0BAD_F00D, 0);
    do_access(1, 0, 32'h30, 32'h0, 0);

    repeat (3) @(negedge clock);
    check(q.size() == 0, "scoreboard_empty",
          32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
